hazard_unit: RTL and testbench

- Detects pipeline hazards and drives the operand-forwarding selects that the EX-stage forwarding mux consumes.
- Sits directly upstream of that mux.
- Shadows the destination registers of the instructions in EX, MEM and WB.
- Generates load-use stalls and multi-cycle multiply holds, and inserts bubbles into ID/EX.

---
 rtl/hazard_unit.sv | 181 ++++++++++++++++++
 tb/tb_hazard_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard detection and EX-stage forwarding select generation for a 5-stage pipe.
// Tracks the EX/MEM/WB writers, raises load-use stalls and holds EX for multi-cycle multiplies.

module hazard_fwd_sel (
  input  logic       en,
  input  logic [4:0] src,
  input  logic       mem_wr,
  input  logic [4:0] mem_dst,
  input  logic       wb_wr,
  input  logic [4:0] wb_dst,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (en && src != 5'd0) begin
      if (mem_wr && mem_dst == src)     sel = 2'b01;
      else if (wb_wr && wb_dst == src)  sel = 2'b10;
    end
  end
endmodule

module hazard_unit #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dst,
  input  logic       id_reg_we,
  input  logic       id_load,
  input  logic       id_mul,
  input  logic       flush,
  output logic       stall_if_id,
  output logic       ex_hold,
  output logic       bubble_mem,
  output logic [1:0] op_a_sel,
  output logic [1:0] op_b_sel
);
  localparam int STAGES  = 2;
  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {RUN, LOAD_STALL, MUL_BUSY} state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic flush_pend, pend_nx;

  // vld_pipe[0] = EX, [1] = MEM, [2] = WB
  logic [STAGES:0] vld_pipe;
  logic [4:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic ex_uses_rs, ex_uses_rt, ex_we, ex_load, ex_mul, mem_we, wb_we;

  logic loaduse, ex_take, mul_in_ex;

  assign mul_in_ex = vld_pipe[0] & ex_mul;
  assign loaduse = id_valid & vld_pipe[0] & ex_load & ex_we & (ex_dst != 5'd0) &
                   ((id_uses_rs & (id_rs == ex_dst)) | (id_uses_rt & (id_rt == ex_dst)));

  logic [NUM_OPS-1:0][4:0] ex_src;
  logic [NUM_OPS-1:0]      ex_use;
  logic [NUM_OPS-1:0][1:0] fwd_sel;

  assign ex_src = {ex_rt, ex_rs};
  assign ex_use = {ex_uses_rt, ex_uses_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hazard_fwd_sel u_sel (
      .en      (vld_pipe[0] & ex_use[g]),
      .src     (ex_src[g]),
      .mem_wr  (vld_pipe[1] & mem_we),
      .mem_dst (mem_dst),
      .wb_wr   (vld_pipe[2] & wb_we),
      .wb_dst  (wb_dst),
      .sel     (fwd_sel[g])
    );
  end

  assign op_a_sel = fwd_sel[0];
  assign op_b_sel = fwd_sel[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      flush_pend <= pend_nx;
    end
  end

  // LOAD_STALL has no behaviour of its own: EX already holds the bubble, so it runs as RUN.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pend_nx     = flush_pend;
    stall_if_id = 1'b0;
    ex_hold     = 1'b0;
    bubble_mem  = 1'b0;
    ex_take     = 1'b0;
    case (state)
      MUL_BUSY: begin
        stall_if_id = mul_in_ex;
        ex_hold     = mul_in_ex;
        bubble_mem  = mul_in_ex;
        cnt_nx      = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = RUN;
        if (flush)       pend_nx  = 1'b1;
      end
      default: begin
        state_nx = RUN;
        pend_nx  = 1'b0;
        if (!(flush || flush_pend)) begin
          if (loaduse) begin
            stall_if_id = 1'b1;
            state_nx    = LOAD_STALL;
          end else begin
            ex_take = 1'b1;
            if (id_valid && id_mul) begin
              cnt_nx   = 4'(MUL_LAT - 1);
              state_nx = MUL_BUSY;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      ex_uses_rs <= 1'b0;
      ex_uses_rt <= 1'b0;
      ex_we      <= 1'b0;
      ex_load    <= 1'b0;
      ex_mul     <= 1'b0;
      mem_dst    <= '0;
      mem_we     <= 1'b0;
      wb_dst     <= '0;
      wb_we      <= 1'b0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      wb_dst      <= mem_dst;
      wb_we       <= mem_we;
      if (bubble_mem) begin
        vld_pipe[1] <= 1'b0;
        mem_we      <= 1'b0;
      end else begin
        vld_pipe[1] <= vld_pipe[0];
        mem_dst     <= ex_dst;
        mem_we      <= ex_we;
      end
      if (ex_take) begin
        vld_pipe[0] <= id_valid;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_dst      <= id_dst;
        ex_uses_rs  <= id_uses_rs;
        ex_uses_rt  <= id_uses_rt;
        ex_we       <= id_reg_we;
        ex_load     <= id_load;
        ex_mul      <= id_mul;
      end else if (!ex_hold) begin
        vld_pipe[0] <= 1'b0;
        ex_uses_rs  <= 1'b0;
        ex_uses_rt  <= 1'b0;
        ex_we       <= 1'b0;
        ex_load     <= 1'b0;
        ex_mul      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with fixed expectations, then random traffic
// compared against an instruction-level pipeline model.

module tb_hazard_unit;
  localparam int MUL_LAT = 4;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       we;
    logic       ld;
    logic       mul;
  } ins_t;

  logic clk, reset, flush_i;
  ins_t id_i;
  logic stall_if_id, ex_hold, bubble_mem;
  logic [1:0] op_a_sel, op_b_sel;
  int errors = 0, checks = 0;

  hazard_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_i.v), .id_rs(id_i.rs), .id_rt(id_i.rt),
    .id_uses_rs(id_i.urs), .id_uses_rt(id_i.urt), .id_dst(id_i.dst),
    .id_reg_we(id_i.we), .id_load(id_i.ld), .id_mul(id_i.mul),
    .flush(flush_i),
    .stall_if_id(stall_if_id), .ex_hold(ex_hold), .bubble_mem(bubble_mem),
    .op_a_sel(op_a_sel), .op_b_sel(op_b_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall, hold, bubble, op_a[1:0], op_b[1:0]}
  logic [6:0] obs;
  assign obs = {stall_if_id, ex_hold, bubble_mem, op_a_sel, op_b_sel};

  // Reference model: whole instructions per stage plus the multiply's age in EX.
  ins_t m_ex = '0, m_mem = '0, m_wb = '0;
  int   m_age = 0;
  logic m_pend = 1'b0;
  logic e_busy, e_kill, e_lu;
  logic [1:0] e_a, e_b;
  logic [6:0] e_obs;

  function automatic logic [1:0] exp_sel(input ins_t ex, input ins_t mem, input ins_t wb, input bit b);
    logic [4:0] s;
    logic u;
    s = b ? ex.rt : ex.rs;
    u = b ? ex.urt : ex.urs;
    if (!ex.v || !u || s == 5'd0) return 2'b00;
    if (mem.v && mem.we && mem.dst == s) return 2'b01;
    if (wb.v && wb.we && wb.dst == s) return 2'b10;
    return 2'b00;
  endfunction

  assign e_busy = m_ex.v && m_ex.mul && (m_age < MUL_LAT);
  assign e_kill = flush_i || m_pend;
  assign e_lu   = id_i.v && m_ex.v && m_ex.ld && m_ex.we && m_ex.dst != 5'd0 &&
                  ((id_i.urs && id_i.rs == m_ex.dst) || (id_i.urt && id_i.rt == m_ex.dst));
  assign e_a    = exp_sel(m_ex, m_mem, m_wb, 1'b0);
  assign e_b    = exp_sel(m_ex, m_mem, m_wb, 1'b1);
  assign e_obs  = {e_busy || (!e_kill && e_lu), e_busy, e_busy, e_a, e_b};

  always @(posedge clk) begin
    if (reset) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0; m_age <= 0; m_pend <= 1'b0;
    end else begin
      m_wb  <= m_mem;
      m_mem <= e_busy ? '0 : m_ex;
      if (e_busy) begin
        m_age <= m_age + 1;
        if (flush_i) m_pend <= 1'b1;
      end else begin
        m_pend <= 1'b0;
        m_ex   <= (e_kill || e_lu) ? '0 : id_i;
        m_age  <= 1;
      end
    end
  end

  function automatic ins_t alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return '{v:1'b1, rs:s, rt:t, urs:1'b1, urt:1'b1, dst:d, we:1'b1, ld:1'b0, mul:1'b0};
  endfunction
  function automatic ins_t lw(input logic [4:0] d, input logic [4:0] s);
    return '{v:1'b1, rs:s, rt:5'd0, urs:1'b1, urt:1'b0, dst:d, we:1'b1, ld:1'b1, mul:1'b0};
  endfunction
  function automatic ins_t mulr(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return '{v:1'b1, rs:s, rt:t, urs:1'b1, urt:1'b1, dst:d, we:1'b1, ld:1'b0, mul:1'b1};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; id_i = '0; flush_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    id_i = alu(5'd3, 5'd1, 5'd2); tick();
    id_i = lw(5'd7, 5'd1); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL reset_c1: obs=%b exp=%b", obs, 7'b0); end
    tick();
    reset = 1'b0; id_i = alu(5'd8, 5'd7, 5'd7); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL reset_c2: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = alu(5'd5, 5'd1, 5'd2); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL reset_nodep1: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = alu(5'd6, 5'd8, 5'd5); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL reset_nodep2: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = '0; #1;
    checks++; if (obs !== 7'b000_10_01) begin errors++; $display("FAIL reset_firstdep: obs=%b exp=%b", obs, 7'b0001001); end
    tick();
  endtask

  task automatic test_alu_chain();
    pulse_reset();
    id_i = alu(5'd3, 5'd1, 5'd2); tick();
    id_i = alu(5'd4, 5'd3, 5'd5); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL alu_indep: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = '0; #1;
    checks++; if (obs !== 7'b000_01_00) begin errors++; $display("FAIL alu_mem_fwd: obs=%b exp=%b", obs, 7'b0000100); end
    tick();
    id_i = alu(5'd3, 5'd1, 5'd2); tick();
    id_i = '0; tick();
    id_i = alu(5'd4, 5'd3, 5'd5); tick();
    id_i = '0; #1;
    checks++; if (obs !== 7'b000_10_00) begin errors++; $display("FAIL alu_wb_fwd: obs=%b exp=%b", obs, 7'b0001000); end
    tick();
    id_i = alu(5'd3, 5'd1, 5'd2); tick();
    id_i = alu(5'd3, 5'd1, 5'd2); tick();
    id_i = alu(5'd4, 5'd3, 5'd3); tick();
    id_i = alu(5'd0, 5'd1, 5'd2); #1;
    checks++; if (obs !== 7'b000_01_01) begin errors++; $display("FAIL alu_mem_priority: obs=%b exp=%b", obs, 7'b0000101); end
    tick();
    id_i = alu(5'd4, 5'd0, 5'd0); tick();
    id_i = '0; #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL alu_r0_nofwd: obs=%b exp=%b", obs, 7'b0); end
    tick();
  endtask

  task automatic test_load_use();
    pulse_reset();
    id_i = lw(5'd7, 5'd1); tick();
    id_i = alu(5'd8, 5'd7, 5'd7); #1;
    checks++; if (obs !== 7'b100_00_00) begin errors++; $display("FAIL lu_stall: obs=%b exp=%b", obs, 7'b1000000); end
    tick(); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL lu_stall_once: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = '0; #1;
    checks++; if (obs !== 7'b000_10_10) begin errors++; $display("FAIL lu_wb_fwd: obs=%b exp=%b", obs, 7'b0001010); end
    tick();
    id_i = lw(5'd0, 5'd1); tick();
    id_i = alu(5'd8, 5'd0, 5'd0); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL lu_r0_nostall: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = lw(5'd7, 5'd1); tick();
    id_i = alu(5'd8, 5'd1, 5'd7); #1;
    checks++; if (obs !== 7'b100_00_00) begin errors++; $display("FAIL lu_rt_stall: obs=%b exp=%b", obs, 7'b1000000); end
    tick(); tick();
    id_i = '0; #1;
    checks++; if (obs !== 7'b000_00_10) begin errors++; $display("FAIL lu_rt_fwd: obs=%b exp=%b", obs, 7'b0000010); end
    tick();
    id_i = lw(5'd7, 5'd1); tick();
    id_i = '{v:1'b1, rs:5'd1, rt:5'd7, urs:1'b1, urt:1'b0, dst:5'd8, we:1'b1, ld:1'b0, mul:1'b0}; #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL lu_rt_unused: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = '0; tick();
  endtask

  task automatic test_mul();
    pulse_reset();
    id_i = alu(5'd1, 5'd5, 5'd6); tick();
    id_i = mulr(5'd9, 5'd1, 5'd2); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL mul_pre: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = alu(5'd10, 5'd9, 5'd1); #1;
    checks++; if (obs !== 7'b111_01_00) begin errors++; $display("FAIL mul_hold1: obs=%b exp=%b", obs, 7'b1110100); end
    tick(); #1;
    checks++; if (obs !== 7'b111_10_00) begin errors++; $display("FAIL mul_hold2: obs=%b exp=%b", obs, 7'b1111000); end
    tick(); #1;
    checks++; if (obs !== 7'b111_00_00) begin errors++; $display("FAIL mul_hold3: obs=%b exp=%b", obs, 7'b1110000); end
    tick(); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL mul_release: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = '0; #1;
    checks++; if (obs !== 7'b000_01_00) begin errors++; $display("FAIL mul_fwd: obs=%b exp=%b", obs, 7'b0000100); end
    tick();
  endtask

  task automatic test_flush();
    pulse_reset();
    id_i = lw(5'd7, 5'd1); tick();
    id_i = alu(5'd8, 5'd7, 5'd7); flush_i = 1'b1; #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL flush_over_lu: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = '0; flush_i = 1'b0; #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL flush_bubble: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = mulr(5'd9, 5'd3, 5'd4); tick();
    id_i = alu(5'd11, 5'd9, 5'd9); flush_i = 1'b1; #1;
    checks++; if (obs !== 7'b111_00_00) begin errors++; $display("FAIL flush_mul_hold: obs=%b exp=%b", obs, 7'b1110000); end
    tick();
    flush_i = 1'b0; tick(); tick(); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL flush_mul_release: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = alu(5'd12, 5'd9, 5'd9); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL flush_sticky_bubble: obs=%b exp=%b", obs, 7'b0); end
    tick();
    id_i = '0; #1;
    checks++; if (obs !== 7'b000_10_10) begin errors++; $display("FAIL flush_sticky_clear: obs=%b exp=%b", obs, 7'b0001010); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    pulse_reset();
    id_i = mulr(5'd9, 5'd1, 5'd2); tick();
    id_i = '0; tick();
    reset = 1'b1; #1;
    checks++; if (obs !== 7'b111_00_00) begin errors++; $display("FAIL rstmul_busy2: obs=%b exp=%b", obs, 7'b1110000); end
    tick();
    reset = 1'b0; #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL rstmul_cleared: obs=%b exp=%b", obs, 7'b0); end
    tick(); #1;
    checks++; if (obs !== 7'b0) begin errors++; $display("FAIL rstmul_run: obs=%b exp=%b", obs, 7'b0); end
    tick();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      id_i.v   = ($urandom_range(0, 4) != 0);
      id_i.rs  = 5'($urandom_range(0, 3));
      id_i.rt  = 5'($urandom_range(0, 3));
      id_i.dst = 5'($urandom_range(0, 3));
      id_i.urs = 1'($urandom_range(0, 1));
      id_i.urt = 1'($urandom_range(0, 1));
      id_i.we  = ($urandom_range(0, 3) != 0);
      id_i.ld  = ($urandom_range(0, 3) == 0);
      id_i.mul = !id_i.ld && ($urandom_range(0, 7) == 0);
      flush_i  = ($urandom_range(0, 11) == 0);
      reset    = ($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if (obs !== e_obs) begin
        errors++;
        $display("FAIL random_cycle%0d: obs=%b exp=%b", n, obs, e_obs);
      end
      tick();
    end
    reset = 1'b0; flush_i = 1'b0; id_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush_i = 1'b0; id_i = '0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_mul();
    test_flush();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
